// File: rtl/wisc_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package wisc_fetch_pkg;

  // Fetch controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  // Top nibble of the halt instruction.
  localparam logic [3:0] HLT_OPCODE = 4'hF;

  // Byte distance between sequential instructions.
  localparam int PC_INC = 2;

  // True when the upper opcode nibble matches the given halt opcode.
  function automatic logic is_halt_op(input logic [3:0] opcode, input logic [3:0] hlt_code);
    return opcode == hlt_code;
  endfunction

endpackage

// File: rtl/fetch_ctrl_pc_incr.sv
// Sequential-PC adder: pc + INC, wrapping modulo 2^ADDR_W without any carry flag.
module pc_incr
  import wisc_fetch_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int INC    = PC_INC
) (
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus
);

  // Plain truncating add; the carry out of the top bit is simply dropped.
  always_comb begin
    pc_plus = pc + ADDR_W'(INC);
  end

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage fetch controller: drives the PC register D input and write-inhibit,
// issues instruction-memory requests, rides out multi-cycle misses, applies
// ID branch redirects and stops fetching when a HLT instruction is delivered.
module fetch_ctrl
  import wisc_fetch_pkg::*;
#(
  parameter int         ADDR_W     = 16,
  parameter int         INSTR_W    = 16,
  parameter int         PC_INC     = wisc_fetch_pkg::PC_INC,
  parameter logic [3:0] HLT_OPCODE = wisc_fetch_pkg::HLT_OPCODE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  pc_q,
  output logic [ADDR_W-1:0]  next_pc,
  output logic               pc_stall_en,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               id_stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc_plus2,
  output logic               if_valid,
  output logic               halted
);

  fetch_state_t      state_reg;
  fetch_state_t      state_next;
  logic              redir_pend_reg;
  logic              redir_pend_next;
  logic [ADDR_W-1:0] redir_pc_reg;
  logic [ADDR_W-1:0] redir_pc_next;
  logic [ADDR_W-1:0] pc_plus;
  logic              rdata_is_hlt;

  pc_incr #(
    .ADDR_W (ADDR_W),
    .INC    (PC_INC)
  ) u_pc_incr (
    .pc      (pc_q),
    .pc_plus (pc_plus)
  );

  // The address and instruction simply pass through; qualification is by imem_req / if_valid.
  assign imem_addr    = pc_q;
  assign if_instr     = imem_rdata;
  assign if_pc_plus2  = pc_plus;
  assign rdata_is_hlt = is_halt_op(imem_rdata[INSTR_W-1 -: 4], HLT_OPCODE);

  // State and pending-redirect registers; the memory shares rst_n, so any
  // in-flight response is dropped together with the pending redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      redir_pend_reg <= 1'b0;
      redir_pc_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      redir_pend_reg <= redir_pend_next;
      redir_pc_reg   <= redir_pc_next;
    end
  end

  // Next-state and output decode. Default is "PC held, nothing delivered".
  always_comb begin
    state_next      = state_reg;
    redir_pend_next = redir_pend_reg;
    redir_pc_next   = redir_pc_reg;
    next_pc         = pc_q;
    pc_stall_en     = 1'b1;
    imem_req        = 1'b0;
    if_valid        = 1'b0;
    halted          = 1'b0;

    case (state_reg)
      IDLE: begin
        state_next = FETCH;
      end

      // FETCH and WAIT share one decode: in FETCH no redirect can be pending,
      // so the redir_pend term only ever matters once a miss is outstanding.
      FETCH, WAIT: begin
        imem_req = 1'b1;
        if (imem_rvalid) begin
          if (flush || redir_pend_reg) begin
            // Returned word belongs to the squashed path: drop it and redirect.
            next_pc         = flush ? branch_target : redir_pc_reg;
            pc_stall_en     = 1'b0;
            redir_pend_next = 1'b0;
            state_next      = FETCH;
          end else if (id_stall) begin
            // IF/ID cannot take the word; hold the PC and ask again.
            state_next = FETCH;
          end else begin
            if_valid = 1'b1;
            next_pc  = pc_plus;
            if (rdata_is_hlt) begin
              // Leave the PC pointing at the HLT itself.
              state_next = HALT;
            end else begin
              pc_stall_en = 1'b0;
              state_next  = FETCH;
            end
          end
        end else begin
          // Miss (or still waiting): hold the address until the single
          // outstanding request completes; remember the newest redirect.
          state_next = WAIT;
          if (flush) begin
            redir_pend_next = 1'b1;
            redir_pc_next   = branch_target;
          end
        end
      end

      HALT: begin
        halted = 1'b1;
        if (flush) begin
          // The HLT was on a mispredicted path; resume at the branch target.
          next_pc     = branch_target;
          pc_stall_en = 1'b0;
          state_next  = FETCH;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios followed by random
// traffic, each cycle compared against a transaction-level reference model.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] pc_q;
  logic [15:0] next_pc;
  logic        pc_stall_en;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        id_stall;
  logic        flush;
  logic [15:0] branch_target;
  logic [15:0] if_instr;
  logic [15:0] if_pc_plus2;
  logic        if_valid;
  logic        halted;

  fetch_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_q          (pc_q),
    .next_pc       (next_pc),
    .pc_stall_en   (pc_stall_en),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .id_stall      (id_stall),
    .flush         (flush),
    .branch_target (branch_target),
    .if_instr      (if_instr),
    .if_pc_plus2   (if_pc_plus2),
    .if_valid      (if_valid),
    .halted        (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: "started", "stopped on HLT", "redirect owed".
  bit          m_live, m_halt, m_redir;
  logic [15:0] m_redir_pc;
  bit          n_halt, n_redir;
  logic [15:0] n_redir_pc;
  logic [15:0] e_npc;
  logic        e_stall, e_req, e_valid, e_halted;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_live = 0; m_halt = 0; m_redir = 0; m_redir_pc = '0;
  endtask

  // Expected outputs for the current inputs, plus the model's next state.
  task automatic model_eval();
    n_halt = m_halt; n_redir = m_redir; n_redir_pc = m_redir_pc;
    e_npc = pc_q; e_stall = 1; e_req = 0; e_valid = 0; e_halted = m_halt;
    if (!m_live) begin
      // one quiet cycle after reset
    end else if (m_halt) begin
      if (flush) begin
        e_npc = branch_target; e_stall = 0; n_halt = 0;
      end
    end else begin
      e_req = 1;
      if (imem_rvalid) begin
        if (flush || m_redir) begin
          e_npc = flush ? branch_target : m_redir_pc;
          e_stall = 0; n_redir = 0;
        end else if (!id_stall) begin
          e_valid = 1;
          e_npc = pc_q + 16'd2;
          if (imem_rdata[15:12] == 4'hF) n_halt = 1;
          else e_stall = 0;
        end
      end else if (flush) begin
        n_redir = 1; n_redir_pc = branch_target;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".req"},     16'(imem_req),    16'(e_req));
    check({tag, ".valid"},   16'(if_valid),    16'(e_valid));
    check({tag, ".stall"},   16'(pc_stall_en), 16'(e_stall));
    check({tag, ".halted"},  16'(halted),      16'(e_halted));
    check({tag, ".next_pc"}, next_pc,          e_npc);
    check({tag, ".addr"},    imem_addr,        pc_q);
    check({tag, ".instr"},   if_instr,         imem_rdata);
    check({tag, ".plus2"},   if_pc_plus2,      pc_q + 16'd2);
  endtask

  // One clock cycle: drive at posedge+1, check at the falling edge, then
  // clock the model and the PC register model.
  task automatic cyc(input string tag, input logic rv, input logic [15:0] rd,
                     input logic st, input logic fl, input logic [15:0] tgt);
    imem_rvalid = rv; imem_rdata = rd; id_stall = st; flush = fl; branch_target = tgt;
    #4;
    model_eval();
    check_all(tag);
    $display("%s pc=%h rv=%0b rd=%h st=%0b fl=%0b tgt=%h -> npc=%h stall=%0b req=%0b valid=%0b halted=%0b",
             tag, pc_q, rv, rd, st, fl, tgt, next_pc, pc_stall_en, imem_req, if_valid, halted);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      model_reset();
    end else begin
      m_live = 1; m_halt = n_halt; m_redir = n_redir; m_redir_pc = n_redir_pc;
      if (!e_stall) pc_q = e_npc;
    end
  endtask

  initial begin
    logic        r_rv, r_st, r_fl;
    logic [15:0] r_rd, r_tgt;

    rst_n = 0; pc_q = '0; imem_rvalid = 0; imem_rdata = '0;
    id_stall = 0; flush = 0; branch_target = '0;
    model_reset();
    @(posedge clk);
    #1;

    // Held in reset: quiet outputs.
    cyc("rst0", 1, 16'h1111, 0, 0, 16'h0000);
    cyc("rst1", 0, 16'h0000, 0, 1, 16'h0200);

    // 1: release, one idle cycle, then hits 0 -> 2 -> 4 -> 6.
    rst_n = 1; pc_q = 16'h0000;
    cyc("t1.idle", 1, 16'h1234, 0, 0, 16'h0000);
    cyc("t1.hit0", 1, 16'h1000, 0, 0, 16'h0000);
    cyc("t1.hit1", 1, 16'h1002, 0, 0, 16'h0000);
    cyc("t1.hit2", 1, 16'h1004, 0, 0, 16'h0000);

    // 2: miss at 0x0010, data three cycles late.
    pc_q = 16'h0010;
    cyc("t2.miss0", 0, 16'h0000, 0, 0, 16'h0000);
    cyc("t2.miss1", 0, 16'h0000, 0, 0, 16'h0000);
    cyc("t2.miss2", 0, 16'h0000, 0, 0, 16'h0000);
    cyc("t2.resp",  1, 16'h2222, 0, 0, 16'h0000);

    // 3: flush to 0x0100 while waiting; stale word is dropped.
    cyc("t3.miss",  0, 16'h0000, 0, 0, 16'h0000);
    cyc("t3.flush", 0, 16'h0000, 0, 1, 16'h0100);
    cyc("t3.wait",  0, 16'h0000, 0, 0, 16'h0000);
    cyc("t3.resp",  1, 16'h3333, 0, 0, 16'h0000);

    // 4: HLT at 0x0020, halt, then flush to 0x0040 resumes.
    pc_q = 16'h0020;
    cyc("t4.hlt",   1, 16'hF000, 0, 0, 16'h0000);
    cyc("t4.halt0", 0, 16'h0000, 0, 0, 16'h0000);
    cyc("t4.halt1", 1, 16'h4444, 1, 0, 16'h0000);
    cyc("t4.flush", 0, 16'h0000, 0, 1, 16'h0040);
    cyc("t4.res",   1, 16'h4040, 0, 0, 16'h0000);

    // 5: id_stall for two hit cycles, then resume.
    cyc("t5.st0", 1, 16'h5550, 1, 0, 16'h0000);
    cyc("t5.st1", 1, 16'h5550, 1, 0, 16'h0000);
    cyc("t5.go",  1, 16'h5550, 0, 0, 16'h0000);

    // Flush beats id_stall and a HLT word on the same cycle.
    cyc("t5.fl",  1, 16'hF000, 1, 1, 16'h0300);
    cyc("t5.hit", 1, 16'h5552, 0, 0, 16'h0000);

    // 6: reset asserted mid-WAIT between clock edges.
    cyc("t6.miss", 0, 16'h0000, 0, 0, 16'h0000);
    imem_rvalid = 0; id_stall = 0; flush = 0;
    #2;
    rst_n = 0;
    #1;
    model_reset();
    model_eval();
    check_all("t6.async");
    $display("t6.async pc=%h -> npc=%h stall=%0b req=%0b valid=%0b halted=%0b",
             pc_q, next_pc, pc_stall_en, imem_req, if_valid, halted);
    @(posedge clk);
    #1;
    rst_n = 1; pc_q = 16'hFFFE;
    cyc("t6.idle", 1, 16'h6666, 0, 0, 16'h0000);
    cyc("t6.wrap", 1, 16'h6666, 0, 0, 16'h0000);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      r_rv  = (m_live && !m_halt) ? ($urandom_range(0, 2) != 0) : 1'b0;
      r_st  = ($urandom_range(0, 3) == 0);
      r_fl  = ($urandom_range(0, 5) == 0);
      r_tgt = 16'($urandom) & 16'hFFFE;
      r_rd  = 16'($urandom);
      if ($urandom_range(0, 9) == 0) r_rd[15:12] = 4'hF;
      else if (r_rd[15:12] == 4'hF) r_rd[15:12] = 4'h7;
      cyc("rnd", r_rv, r_rd, r_st, r_fl, r_tgt);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
